// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, reset/NOP constants, opcodes
// and the fetch-queue entry layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  // Sequential word address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/grant/response bus between fetch and imem.
interface if_stage_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr}; when empty the head keeps showing the
// last entry consumed so decode-facing outputs hold their previous values.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int             AW       = $clog2(DEPTH),
  localparam int             CW       = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fq_entry_t     head
);

  fq_entry_t         mem [DEPTH];
  fq_entry_t         last;
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last   <= '{pc: RESET_PC, instr: NOP_INSTR};
    end else begin
      // A pop in a flush cycle is still a consumed entry.
      if (do_pop) last <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? last : mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, credit-limited imem requests,
// stale-response discard on redirect, and the decode-facing fetch queue.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  if_stage_if.master      imem,
  output logic            instr_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] instrCode,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_4
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0]   count, outstanding, discard, out_next;
  logic [CW:0]     credit_used;
  logic            gnt_fire, rsp, drop, push, pop;
  logic            fq_full, fq_empty;
  fq_entry_t       head;

  // Queued plus in-flight words never exceed the queue depth, so a
  // response always has a free slot.
  assign credit_used   = {1'b0, count} + {1'b0, outstanding};
  assign imem.imem_req  = !rst && (credit_used < (CW+1)'(FQ_DEPTH));
  assign imem.imem_addr = fetch_pc;

  assign gnt_fire = imem.imem_req && imem.imem_gnt;
  assign rsp      = imem.imem_rvalid && (outstanding != '0);
  assign drop     = rsp && (discard != '0);
  assign push     = rsp && !drop && !redirect_valid;
  assign pop      = instr_valid && id_ready;
  assign out_next = outstanding + CW'(gnt_fire) - CW'(rsp);
  assign target   = redirect_pc & ~32'h3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= target;
        rsp_pc   <= target;
        discard  <= out_next;
      end else begin
        if (gnt_fire) fetch_pc <= pc_next(fetch_pc);
        if (push)     rsp_pc   <= pc_next(rsp_pc);
        if (drop)     discard  <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH    (FQ_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: rsp_pc, instr: imem.imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (count),
    .head      (head)
  );

  assign instr_valid = !fq_empty;
  assign instrCode   = head.instr;
  assign PC          = head.pc;
  assign PC_4        = pc_next(head.pc);

  a_req_has_room: assert property (@(posedge clk) disable iff (rst)
                                   imem.imem_req |-> !fq_full);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order imem model (grant every cycle,
// responses delayed by at least one cycle, gated by rsp_en).
module tb_if_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, id_ready;
  logic [31:0] instrCode, PC, PC_4;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0), .FQ_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .instr_valid    (instr_valid),
    .id_ready       (id_ready),
    .instrCode      (instrCode),
    .PC             (PC),
    .PC_4           (PC_4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } dec_t;

  dec_t        dq[$];
  logic [31:0] gq[$];
  logic [31:0] pq[$];
  bit          rsp_en;
  int          nvec, nerr, gbase;
  bit          found;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: log grants/consumptions before the edge, then drive the next response.
  task automatic tick();
    logic fire;
    logic [31:0] fa;
    #1;
    fire = bus.imem_req && bus.imem_gnt;
    fa   = bus.imem_addr;
    if (fire) begin
      gq.push_back(fa);
      pq.push_back(fa);
    end
    if (instr_valid && id_ready) dq.push_back('{PC, PC_4, instrCode});
    @(posedge clk);
    #1;
    if (rsp_en && !rst && pq.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word(pq.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
  endtask

  task automatic check_seq(input string tag, input logic [31:0] base, input int min_n);
    chk({tag, "_cnt"}, 32'(dq.size() >= min_n), 32'd1);
    for (int i = 0; i < dq.size(); i++) begin
      chk({tag, "_pc"},    dq[i].pc,    base + 32'(4 * i));
      chk({tag, "_instr"}, dq[i].instr, word(base + 32'(4 * i)));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_rvalid = 1'b0;
    pq.delete(); gq.delete(); dq.delete();
    tick(); tick();
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    rsp_en = 1'b1;

    // Reset state
    tick(); tick(); #1;
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid),  32'd0);
    chk("rst_instr", instrCode, 32'h0000_0013);
    chk("rst_pc",    PC,        32'h0);
    chk("rst_pc4",   PC_4,      32'h4);

    // Free-running fetch, id_ready = 1
    rst = 1'b0; #1;
    chk("t1_req0",  32'(bus.imem_req), 32'd1);
    chk("t1_addr0", bus.imem_addr, 32'h0);
    tick();
    chk("t1_req1",  32'(bus.imem_req), 32'd1);
    chk("t1_addr1", bus.imem_addr, 32'h4);
    tick();
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_pc",    PC,        32'h0);
    chk("t1_instr", instrCode, word(32'h0));
    chk("t1_pc4",   PC_4,      32'h4);
    chk("t1_req2",  32'(bus.imem_req), 32'd0);
    tick();
    chk("t1_pc_b",  PC, 32'h4);
    chk("t1_addr2", bus.imem_addr, 32'h8);
    repeat (8) tick();
    chk("t1_g0", gq[0], 32'h0);
    chk("t1_g1", gq[1], 32'h4);
    chk("t1_g2", gq[2], 32'h8);
    check_seq("t1_seq", 32'h0, 5);

    // Back-pressure from decode
    do_reset();
    id_ready = 1'b0;
    rst = 1'b0;
    repeat (5) tick();
    chk("t2_grants", 32'(gq.size()), 32'd2);
    chk("t2_req",    32'(bus.imem_req), 32'd0);
    chk("t2_valid",  32'(instr_valid), 32'd1);
    chk("t2_pc",     PC, 32'h0);
    chk("t2_instr",  instrCode, word(32'h0));
    id_ready = 1'b1;
    repeat (12) tick();
    check_seq("t2_seq", 32'h0, 6);

    // Redirect with two fetches outstanding
    rsp_en = 1'b0;
    repeat (8) tick();
    chk("t3_pend",  32'(pq.size()), 32'd2);
    chk("t3_req",   32'(bus.imem_req), 32'd0);
    chk("t3_valid", 32'(instr_valid), 32'd0);
    gbase = gq.size();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("t3_addr", bus.imem_addr, 32'h0000_0100);
    rsp_en = 1'b1;
    dq.delete();
    repeat (10) tick();
    chk("t3_gfirst", 32'(gq.size() > gbase), 32'd1);
    if (gq.size() > gbase) chk("t3_gaddr", gq[gbase], 32'h100);
    check_seq("t3_seq", 32'h100, 2);

    // Redirect coinciding with a response and a pop
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid && bus.imem_rvalid) found = 1'b1;
      else tick();
    end
    chk("t4_found", 32'(found), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("t4_valid", 32'(instr_valid), 32'd0);
    chk("t4_addr",  bus.imem_addr, 32'h200);
    gbase = gq.size();
    dq.delete();
    repeat (10) tick();
    if (gq.size() > gbase) chk("t4_gaddr", gq[gbase], 32'h200);
    check_seq("t4_seq", 32'h200, 2);

    // Address wrap at the top of memory
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
    gbase = gq.size();
    dq.delete();
    repeat (10) tick();
    chk("t5_cnt", 32'(dq.size() >= 2 && gq.size() >= gbase + 2), 32'd1);
    if (gq.size() >= gbase + 2) chk("t5_gwrap", gq[gbase+1], 32'h0);
    if (dq.size() >= 2) begin
      chk("t5_pc",    dq[0].pc,    32'hFFFF_FFFC);
      chk("t5_pc4",   dq[0].pc4,   32'h0);
      chk("t5_instr", dq[0].instr, word(32'hFFFF_FFFC));
      chk("t5_pc_n",  dq[1].pc,    32'h0);
      chk("t5_pc4_n", dq[1].pc4,   32'h4);
    end

    // Asynchronous reset with a full queue
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    repeat (8) tick();
    chk("t6_valid_pre", 32'(instr_valid), 32'd1);
    chk("t6_pc_pre",    PC, 32'h300);
    #3 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_req",   32'(bus.imem_req), 32'd0);
    chk("t6_pc",    PC,        32'h0);
    chk("t6_pc4",   PC_4,      32'h4);
    chk("t6_instr", instrCode, 32'h0000_0013);
    pq.delete(); gq.delete(); dq.delete();
    bus.imem_rvalid = 1'b0;
    id_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("t6_req_rel",  32'(bus.imem_req), 32'd1);
    chk("t6_addr_rel", bus.imem_addr, 32'h0);
    repeat (4) tick();
    check_seq("t6_seq", 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
